hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline control unit that drives the ID/EX register's enable and flush and the IF/ID and PC enables.
//  Detects load-use hazards and EX-stage redirects (branch taken, jal, jalr).
//  Freezes the pipeline while instruction or data memory is busy, and replays a redirect once the freeze lifts.
//  Keeps saturating stall and flush counters for performance monitoring.
// PARAMETERS
//  CNT_W         32    width of stall_cnt and flush_cnt
//  WAIT_TIMEOUT  1024  consecutive memory-wait cycles before wait_err is set
// PORTS
//  clk          in   1  clock; all state updates on the rising edge
//  rst          in   1  synchronous, active-high reset
//  ID_rs1       in   5  rs1 address of the instruction in ID
//  ID_rs2       in   5  rs2 address of the instruction in ID
//  ID_use_rs1   in   1  ID instruction reads rs1
//  ID_use_rs2   in   1  ID instruction reads rs2
//  EX_Memread   in   1  instruction in EX is a load
//  EX_rd_addr   in   5  destination register of the instruction in EX
//  EX_jump      in   2  00 none, 01 branch, 10 jal, 11 jalr
//  branch_taken in   1  EX branch condition is true
//  IM_stall     in   1  instruction memory busy
//  DM_stall     in   1  data memory busy
//  PC_write     out  1  PC update enable
//  IFID_write   out  1  IF/ID capture enable
//  IDEX_stall   out  1  ID/EX capture enable (1 = capture, 0 = hold)
//  IFID_flush   out  1  squash IF/ID contents
//  IDEX_flush   out  1  zero the Memread, Memwrite, Regwrite and jump fields of ID/EX
//  stall_cnt    out  CNT_W  cycles with PC_write=0; saturates at all-ones
//  flush_cnt    out  CNT_W  cycles with IFID_flush=1; saturates at all-ones
//  wait_err     out  1  sticky flag: memory wait reached WAIT_TIMEOUT
// BEHAVIOUR
//  Definitions:
//   - redirect  = (EX_jump==01 & branch_taken) | EX_jump[1]
//   - load_use  = EX_Memread & EX_rd_addr!=0 & ((ID_use_rs1 & ID_rs1==EX_rd_addr) | (ID_use_rs2 & ID_rs2==EX_rd_addr))
//   - busy      = IM_stall | DM_stall
//  Enable and flush outputs are combinational from the current state and inputs; there is no added latency.
//  While rst=1 (same-cycle override):
//   - all enables and flushes are 0
//   - next edge: state=RUN, pend_flush=0, wait_cnt=0, stall_cnt=0, flush_cnt=0, wait_err=0
//  Normal output, all conditions except those below: PC_write=IFID_write=IDEX_stall=1, both flushes 0.
//  Decision priority: busy > (redirect | pend_flush) > load_use.
//  States:
//   - RUN
//   - MWAIT
//  RUN:
//   - busy: PC_write=IFID_write=IDEX_stall=0, flushes 0; pend_flush<=redirect; wait_cnt<=1; go to MWAIT
//   - redirect: PC_write=IFID_write=IDEX_stall=1, IFID_flush=IDEX_flush=1
//   - load_use: PC_write=IFID_write=0, IDEX_stall=1, IDEX_flush=1 (one bubble inserted into EX)
//  MWAIT:
//   - busy: all enables 0, flushes 0
//     - pend_flush<=pend_flush|redirect
//     - wait_cnt increments, saturating at WAIT_TIMEOUT
//     - wait_err<=1 when wait_cnt reaches WAIT_TIMEOUT
//   - !busy: evaluate exactly as RUN with redirect replaced by (redirect|pend_flush); clear pend_flush; wait_cnt<=0; go to RUN
//  Each redirect flushes exactly once, including one that is pending across a wait.
//  A load-use that coincides with a redirect is ignored, since the dependent instruction is flushed.
//  Counters:
//   - stall_cnt increments on every non-reset cycle with PC_write=0
//   - flush_cnt increments on every non-reset cycle with IFID_flush=1
//   - both saturate and never wrap
//  wait_err is cleared only by rst.
// STRUCTURE
//  Package pipe_ctrl_pkg:
//   - state enum {RUN, MWAIT}
//   - EX_jump encoding constants JMP_NONE, JMP_BR, JMP_JAL, JMP_JALR
//  Sub-module sat_counter #(W): synchronous clear and increment, saturating.
//   - instantiated for stall_cnt and flush_cnt
//   - also used for wait_cnt with W=$clog2(WAIT_TIMEOUT+1)
// TESTING
//  1. EX_Memread=1, EX_rd_addr=5, ID_rs1=5, ID_use_rs1=1 -> one cycle of PC_write=0, IFID_write=0, IDEX_stall=1, IDEX_flush=1; next cycle normal; stall_cnt=1.
//  2. Same as 1 but EX_rd_addr=0, or ID_use_rs1=0 -> no stall; all enables 1.
//  3. EX_jump=01, branch_taken=1 -> IFID_flush=IDEX_flush=1, PC_write=1, flush_cnt=1; with branch_taken=0 no flush.
//  4. EX_jump=10 (jal) with DM_stall=1 for 3 cycles -> 3 frozen cycles, flushes 0; exit cycle flushes exactly once; stall_cnt=3.
//  5. IM_stall held for WAIT_TIMEOUT cycles -> wait_err=1 and stays 1 after IM_stall drops, until rst.
//  6. rst=1 in MWAIT with pend_flush=1 -> outputs 0 that cycle; next cycle state RUN, counters 0, no stale flush.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding and the EX-stage jump encoding.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_t;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_BR   = 2'b01;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_JALR = 2'b11;

  // Taken branches and both jump kinds change the fetch stream.
  function automatic logic is_redirect(input logic [1:0] jump, input logic taken);
    return ((jump == JMP_BR) && taken) || jump[1];
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard controller.
// The slave modport is the controller; the master modport is the datapath.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic             EX_Memread;
  logic [4:0]       EX_rd_addr;
  logic [1:0]       EX_jump;
  logic             branch_taken;
  logic             IM_stall;
  logic             DM_stall;
  logic             PC_write;
  logic             IFID_write;
  logic             IDEX_stall;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             wait_err;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_Memread, EX_rd_addr,
           EX_jump, branch_taken, IM_stall, DM_stall,
    input  PC_write, IFID_write, IDEX_stall, IFID_flush, IDEX_flush,
           stall_cnt, flush_cnt, wait_err
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_Memread, EX_rd_addr,
           EX_jump, branch_taken, IM_stall, DM_stall,
    output PC_write, IFID_write, IDEX_stall, IFID_flush, IDEX_flush,
           stall_cnt, flush_cnt, wait_err
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: clear wins over increment.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, memory-wait
// freeze with redirect replay, and saturating stall/flush counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int WAIT_TIMEOUT = 1024
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam int               WAIT_W   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_TIMEOUT);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              pend_flush_r;
  logic              pend_flush_nxt_s;
  logic              wait_err_r;
  logic              wait_err_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              wait_inc_s;
  logic              wait_clr_s;
  logic              redirect_s;
  logic              load_use_s;
  logic              busy_s;
  logic              wait_reach_s;
  logic              pc_write_s;
  logic              ifid_write_s;
  logic              idex_stall_s;
  logic              ifid_flush_s;
  logic              idex_flush_s;
  logic [CNT_W-1:0]  stall_cnt_s;
  logic [CNT_W-1:0]  flush_cnt_s;

  assign redirect_s = is_redirect(hz.EX_jump, hz.branch_taken);
  assign busy_s     = hz.IM_stall | hz.DM_stall;
  assign load_use_s = hz.EX_Memread && (hz.EX_rd_addr != 5'd0) &&
                      ((hz.ID_use_rs1 && (hz.ID_rs1 == hz.EX_rd_addr)) ||
                       (hz.ID_use_rs2 && (hz.ID_rs2 == hz.EX_rd_addr)));
  // True when the wait counter's next value lands on the timeout.
  assign wait_reach_s = ({1'b0, wait_cnt_r} + {{WAIT_W{1'b0}}, 1'b1}) >= {1'b0, WAIT_MAX};

  // Next-state and output decode; busy beats redirect beats load-use.
  always_comb begin
    state_nxt_s      = state_r;
    pend_flush_nxt_s = pend_flush_r;
    wait_err_nxt_s   = wait_err_r;
    wait_inc_s       = 1'b0;
    wait_clr_s       = 1'b0;
    pc_write_s       = 1'b1;
    ifid_write_s     = 1'b1;
    idex_stall_s     = 1'b1;
    ifid_flush_s     = 1'b0;
    idex_flush_s     = 1'b0;
    if (rst) begin
      state_nxt_s      = RUN;
      pend_flush_nxt_s = 1'b0;
      wait_err_nxt_s   = 1'b0;
      wait_clr_s       = 1'b1;
      pc_write_s       = 1'b0;
      ifid_write_s     = 1'b0;
      idex_stall_s     = 1'b0;
    end else if (busy_s) begin
      state_nxt_s      = MWAIT;
      pend_flush_nxt_s = (state_r == MWAIT) ? (pend_flush_r | redirect_s) : redirect_s;
      wait_inc_s       = 1'b1;
      pc_write_s       = 1'b0;
      ifid_write_s     = 1'b0;
      idex_stall_s     = 1'b0;
      if (wait_reach_s) begin
        wait_err_nxt_s = 1'b1;
      end else begin
        wait_err_nxt_s = wait_err_r;
      end
    end else begin
      case (state_r)
        RUN: begin
          state_nxt_s      = RUN;
          pend_flush_nxt_s = 1'b0;
        end
        MWAIT: begin
          // Leaving the freeze replays any redirect seen while frozen.
          state_nxt_s      = RUN;
          pend_flush_nxt_s = 1'b0;
          wait_clr_s       = 1'b1;
        end
        default: begin
          state_nxt_s      = RUN;
          pend_flush_nxt_s = 1'b0;
          wait_clr_s       = 1'b1;
        end
      endcase
      if (redirect_s || pend_flush_r) begin
        ifid_flush_s = 1'b1;
        idex_flush_s = 1'b1;
      end else if (load_use_s) begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        idex_flush_s = 1'b1;
      end else begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
      end
    end
  end

  // State, pending-flush and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      pend_flush_r <= 1'b0;
      wait_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pend_flush_r <= pend_flush_nxt_s;
      wait_err_r   <= wait_err_nxt_s;
    end
  end

  sat_counter #(.W(WAIT_W), .MAX(WAIT_MAX)) u_wait_cnt (
    .clk   (clk),
    .clr   (wait_clr_s),
    .inc   (wait_inc_s),
    .count (wait_cnt_r)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (~rst & ~pc_write_s),
    .count (stall_cnt_s)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (~rst & ifid_flush_s),
    .count (flush_cnt_s)
  );

  assign hz.PC_write   = pc_write_s;
  assign hz.IFID_write = ifid_write_s;
  assign hz.IDEX_stall = idex_stall_s;
  assign hz.IFID_flush = ifid_flush_s;
  assign hz.IDEX_flush = idex_flush_s;
  assign hz.stall_cnt  = stall_cnt_s;
  assign hz.flush_cnt  = flush_cnt_s;
  assign hz.wait_err   = wait_err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic,
// expected outputs from a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int CNT_W = 6;
  localparam int TO    = 20;
  localparam int SAT   = (1 << CNT_W) - 1;

  typedef struct {
    logic       pc;
    logic       ifid;
    logic       idex;
    logic       ifid_fl;
    logic       idex_fl;
    logic [31:0] sc;
    logic [31:0] fc;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W), .WAIT_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   pops   = 0;

  // Model state: consecutive busy cycles, pending redirect, sticky error, counts.
  int busy_run = 0;
  bit m_pend   = 1'b0;
  bit m_err    = 1'b0;
  int m_sc     = 0;
  int m_fc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                     input logic [1:0] j, input logic bt, input logic im, input logic dm);
    exp_t e;
    bit red, lu;
    rst = r;
    hz.ID_rs1 = rs1; hz.ID_rs2 = rs2; hz.ID_use_rs1 = u1; hz.ID_use_rs2 = u2;
    hz.EX_Memread = mr; hz.EX_rd_addr = rd; hz.EX_jump = j; hz.branch_taken = bt;
    hz.IM_stall = im; hz.DM_stall = dm;
    e.sc  = 32'(m_sc);
    e.fc  = 32'(m_fc);
    e.err = m_err;
    red = ((j == 2'b01) && bt) || (j >= 2'b10);
    lu  = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (r) begin
      {e.pc, e.ifid, e.idex, e.ifid_fl, e.idex_fl} = 5'b00000;
      busy_run = 0; m_pend = 1'b0; m_err = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (im || dm) begin
        {e.pc, e.ifid, e.idex, e.ifid_fl, e.idex_fl} = 5'b00000;
        m_pend   = m_pend | red;
        busy_run = (busy_run + 1 > TO) ? TO : busy_run + 1;
        if (busy_run >= TO) m_err = 1'b1;
      end else begin
        if (red || m_pend)
          {e.pc, e.ifid, e.idex, e.ifid_fl, e.idex_fl} = 5'b11111;
        else if (lu)
          {e.pc, e.ifid, e.idex, e.ifid_fl, e.idex_fl} = 5'b00101;
        else
          {e.pc, e.ifid, e.idex, e.ifid_fl, e.idex_fl} = 5'b11100;
        m_pend   = 1'b0;
        busy_run = 0;
      end
      if (!e.pc && m_sc < SAT) m_sc++;
      if (e.ifid_fl && m_fc < SAT) m_fc++;
    end
    q.push_back(e);
    pushes++;
  endtask

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                      input logic [1:0] j, input logic bt, input logic im, input logic dm);
    @(posedge clk);
    #1;
    cyc(r, rs1, rs2, u1, u2, mr, rd, j, bt, im, dm);
  endtask

  task automatic idle(input logic r);
    step(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      pops++;
      chk("PC_write",   32'(hz.PC_write),   32'(e.pc));
      chk("IFID_write", 32'(hz.IFID_write), 32'(e.ifid));
      chk("IDEX_stall", 32'(hz.IDEX_stall), 32'(e.idex));
      chk("IFID_flush", 32'(hz.IFID_flush), 32'(e.ifid_fl));
      chk("IDEX_flush", 32'(hz.IDEX_flush), 32'(e.idex_fl));
      chk("stall_cnt",  32'(hz.stall_cnt),  e.sc);
      chk("flush_cnt",  32'(hz.flush_cnt),  e.fc);
      chk("wait_err",   32'(hz.wait_err),   32'(e.err));
    end
  end

  initial begin
    logic [4:0] a, b, d;
    logic [1:0] j;
    rst = 1'b1;
    idle(1'b1);
    idle(1'b1);
    // Load-use bubble then a clean cycle.
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    // No hazard for x0 destination or unused rs1.
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0);
    // Branch taken and not taken.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    // jal held across a three-cycle data-memory wait, then replayed once.
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b10, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    // Instruction-memory wait long enough to trip the timeout, then sticky.
    for (int i = 0; i < TO + 3; i++)
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    // Reset while frozen with a pending redirect: no stale flush afterwards.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    // Random traffic with narrow register ranges to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      d = 5'($urandom_range(0, 3));
      j = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, a, b,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), d, j, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end
    idle(1'b0);
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(q.size()), 32'd0);
    chk("sb_pops", 32'(pops), 32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
